// File: rtl/response_checker_pkg.sv
// Shared definitions for the response checker: note geometry, FSM state encoding
// and the level-length clamp used when a level is loaded.
package response_checker_pkg;

    localparam int NOTE_W    = 4;
    localparam int MAX_NOTES = 4;
    localparam int DATA_W    = NOTE_W * MAX_NOTES;
    localparam int LEN_W     = 4;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        ARMED        = 3'd1,
        WAIT_PRESS   = 3'd2,
        WAIT_RELEASE = 3'd3,
        PASS         = 3'd4,
        FAIL         = 3'd5
    } state_t;

    // Levels longer than the data word can hold are treated as full-length levels.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        if (len > LEN_W'(MAX_NOTES)) return LEN_W'(MAX_NOTES);
        return len;
    endfunction

endpackage

// File: rtl/response_checker_timeout_counter.sv
// Per-note timeout: counts enabled cycles since the last clear and flags expiry
// once TIMEOUT_CYCLES-1 is reached (then holds there).
module timeout_counter #(
    parameter int TIMEOUT_CYCLES = 25000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] count;

    assign expired = (count == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/response_checker.sv
// Checks player key presses against a stored note sequence, pulsing note_ok per
// correct note and latching pass/fail.
//
// Handshake note: there is no valid/ready pair here; load_level and start_check
// are level-sensitive commands sampled every cycle (load_level has priority), and
// a key press is the cycle where keys goes non-zero after a cycle of all-zero keys.
module response_checker
    import response_checker_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 25000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] level_data,
    input  logic [LEN_W-1:0]  level_length,
    input  logic              load_level,
    input  logic              start_check,
    input  logic [NOTE_W-1:0] keys,
    output logic              busy,
    output logic              note_ok,
    output logic              pass,
    output logic              fail,
    output logic [LEN_W-1:0]  notes_left,
    output state_t            state_dbg
);

    state_t            state, state_n;
    logic [DATA_W-1:0] stored_data;
    logic [LEN_W-1:0]  stored_len;
    logic [DATA_W-1:0] exp_q, exp_n;
    logic [NOTE_W-1:0] keys_q;
    logic [LEN_W-1:0]  left_n;
    logic              note_ok_n, pass_n, fail_n, busy_n;
    logic              tmr_clear, tmr_expired, in_busy_state, press;

    assign in_busy_state = (state == ARMED) || (state == WAIT_PRESS) || (state == WAIT_RELEASE);
    assign press         = (keys_q == '0) && (keys != '0);
    assign state_dbg     = state;

    timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (tmr_clear),
        .enable  (in_busy_state),
        .expired (tmr_expired)
    );

    always_comb begin
        state_n   = state;
        exp_n     = exp_q;
        left_n    = notes_left;
        note_ok_n = 1'b0;
        pass_n    = pass;
        fail_n    = fail;
        tmr_clear = 1'b0;
        if (load_level) begin
            state_n = IDLE;
            left_n  = '0;
            pass_n  = 1'b0;
            fail_n  = 1'b0;
        end else if (start_check) begin
            exp_n     = stored_data;
            left_n    = stored_len;
            fail_n    = 1'b0;
            pass_n    = (stored_len == '0);
            tmr_clear = 1'b1;
            state_n   = (stored_len == '0) ? PASS : ARMED;
        end else begin
            unique case (state)
                // ARMED and WAIT_RELEASE both wait for every key to be let go.
                ARMED, WAIT_RELEASE: begin
                    if (tmr_expired) begin
                        fail_n  = 1'b1;
                        state_n = FAIL;
                    end else if (keys == '0) begin
                        state_n = WAIT_PRESS;
                    end
                end
                WAIT_PRESS: begin
                    if (press) begin
                        if (keys == exp_q[DATA_W-1 -: NOTE_W]) begin
                            note_ok_n = 1'b1;
                            tmr_clear = 1'b1;
                            left_n    = notes_left - LEN_W'(1);
                            exp_n     = {exp_q[DATA_W-NOTE_W-1:0], {NOTE_W{1'b0}}};
                            if (notes_left == LEN_W'(1)) begin
                                pass_n  = 1'b1;
                                state_n = PASS;
                            end else begin
                                state_n = WAIT_RELEASE;
                            end
                        end else begin
                            fail_n  = 1'b1;
                            state_n = FAIL;
                        end
                    end else if (tmr_expired) begin
                        fail_n  = 1'b1;
                        state_n = FAIL;
                    end
                end
                default: ;
            endcase
        end
        busy_n = (state_n == ARMED) || (state_n == WAIT_PRESS) || (state_n == WAIT_RELEASE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            stored_data <= '0;
            stored_len  <= '0;
            exp_q       <= '0;
            keys_q      <= '0;
            notes_left  <= '0;
            note_ok     <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            busy        <= 1'b0;
        end else begin
            if (load_level) begin
                stored_data <= level_data;
                stored_len  <= clamp_len(level_length);
            end
            state      <= state_n;
            exp_q      <= exp_n;
            keys_q     <= keys;
            notes_left <= left_n;
            note_ok    <= note_ok_n;
            pass       <= pass_n;
            fail       <= fail_n;
            busy       <= busy_n;
        end
    end

endmodule

// File: tb/tb_response_checker.sv
// Bench for response_checker: directed game scenarios followed by random key
// traffic, every cycle compared against a queue-based reference model.
module tb_response_checker;
    import response_checker_pkg::*;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] level_data = '0;
    logic [3:0]  level_length = '0;
    logic        load_level = 1'b0;
    logic        start_check = 1'b0;
    logic [3:0]  keys = '0;
    logic        busy, note_ok, pass, fail;
    logic [3:0]  notes_left;
    state_t      state_dbg;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    response_checker #(.TIMEOUT_CYCLES(T)) dut (
        .clk          (clk),
        .reset        (reset),
        .level_data   (level_data),
        .level_length (level_length),
        .load_level   (load_level),
        .start_check  (start_check),
        .keys         (keys),
        .busy         (busy),
        .note_ok      (note_ok),
        .pass         (pass),
        .fail         (fail),
        .notes_left   (notes_left),
        .state_dbg    (state_dbg)
    );

    // Reference model: remaining notes as a queue, plus "waiting for all keys up" flag.
    logic [15:0] m_data;
    int          m_len;
    logic [3:0]  m_q[$];
    bit          m_active, m_wait_zero, m_pass, m_fail, m_note_ok;
    int          m_timer;
    logic [3:0]  m_prev;

    task automatic model_step();
        m_note_ok = 1'b0;
        if (!reset) begin
            m_data = '0; m_len = 0; m_q.delete();
            m_active = 1'b0; m_wait_zero = 1'b0; m_timer = 0;
            m_pass = 1'b0; m_fail = 1'b0;
        end else if (load_level) begin
            m_data = level_data;
            m_len  = (int'(level_length) > 4) ? 4 : int'(level_length);
            m_q.delete();
            m_active = 1'b0; m_pass = 1'b0; m_fail = 1'b0;
        end else if (start_check) begin
            m_q.delete();
            for (int i = 0; i < m_len; i++) m_q.push_back(m_data[15-4*i -: 4]);
            m_fail = 1'b0;
            m_pass = (m_len == 0);
            m_active = (m_len != 0);
            m_wait_zero = 1'b1;
            m_timer = 0;
        end else if (m_active) begin
            if (m_wait_zero) begin
                if (m_timer == T-1) begin
                    m_fail = 1'b1; m_active = 1'b0;
                end else begin
                    m_timer++;
                    if (keys == 4'h0) m_wait_zero = 1'b0;
                end
            end else if (m_prev == 4'h0 && keys != 4'h0) begin
                if (keys == m_q[0]) begin
                    void'(m_q.pop_front());
                    m_note_ok = 1'b1;
                    m_timer = 0;
                    if (m_q.size() == 0) begin
                        m_pass = 1'b1; m_active = 1'b0;
                    end else begin
                        m_wait_zero = 1'b1;
                    end
                end else begin
                    m_fail = 1'b1; m_active = 1'b0;
                end
            end else if (m_timer == T-1) begin
                m_fail = 1'b1; m_active = 1'b0;
            end else begin
                m_timer++;
            end
        end
        m_prev = reset ? keys : 4'h0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check("busy",       32'(busy),       32'(m_active));
        check("note_ok",    32'(note_ok),    32'(m_note_ok));
        check("pass",       32'(pass),       32'(m_pass));
        check("fail",       32'(fail),       32'(m_fail));
        check("notes_left", 32'(notes_left), 32'(m_q.size()));
    endtask

    task automatic load(input logic [15:0] d, input logic [3:0] l);
        level_data = d; level_length = l; load_level = 1'b1;
        cycle();
        load_level = 1'b0;
    endtask

    task automatic start();
        start_check = 1'b1;
        cycle();
        start_check = 1'b0;
    endtask

    task automatic press(input logic [3:0] k);
        keys = k;
        cycle();
        keys = 4'h0;
        cycle();
    endtask

    initial begin
        // reset
        reset = 1'b0;
        cycle();
        cycle();
        check("reset_state", 32'(state_dbg), 32'(IDLE));
        reset = 1'b1;
        cycle();

        // 1: full correct sequence
        load(16'h1248, 4'd4);
        start();
        cycle();
        press(4'h1); press(4'h2); press(4'h4);
        keys = 4'h8; cycle();
        check("s1_pass", 32'(pass), 32'd1);
        keys = 4'h0; cycle(); cycle();

        // 2: wrong second note, then an ignored press
        start();
        cycle();
        press(4'h1); press(4'h4); press(4'h2);
        check("s2_fail_held", 32'(fail), 32'd1);

        // 3: timeout with no keys, then retry
        start();
        for (int i = 0; i < 10; i++) cycle();
        check("s3_timeout", 32'(fail), 32'd1);
        start();
        check("s3_retry_left", 32'(notes_left), 32'd4);

        // 4: key already held at start
        keys = 4'h1;
        start();
        keys = 4'h1; cycle(); cycle();
        keys = 4'h0; cycle();
        press(4'h1);

        // 5: reset mid-sequence after two notes
        start();
        cycle();
        press(4'h1); press(4'h2);
        keys = 4'h4; reset = 1'b0;
        cycle();
        check("s5_state", 32'(state_dbg), 32'(IDLE));
        cycle();
        reset = 1'b1; keys = 4'h0;
        cycle();

        // 6: length boundaries and load/start collision
        load(16'h1248, 4'd0);
        start();
        check("s6_len0_pass", 32'(pass), 32'd1);
        load(16'h8421, 4'd9);
        start();
        check("s6_clamp", 32'(notes_left), 32'd4);
        load_level = 1'b1; start_check = 1'b1;
        cycle();
        load_level = 1'b0; start_check = 1'b0;
        check("s6_load_wins", 32'(busy), 32'd0);
        cycle();

        // random traffic
        for (int n = 0; n < 600; n++) begin
            int r;
            reset       = ($urandom_range(0, 99) != 0);
            load_level  = ($urandom_range(0, 39) == 0);
            start_check = ($urandom_range(0, 24) == 0);
            if (load_level) begin
                level_data   = 16'($urandom);
                level_length = 4'($urandom_range(0, 9));
            end
            r = $urandom_range(0, 9);
            if (r < 5)                         keys = 4'h0;
            else if (r < 8 && m_q.size() > 0)  keys = m_q[0];
            else                               keys = 4'($urandom);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
